dct_2d_seq: RTL and testbench
=============================

Name: dct_2d_seq

Overview:
- Sequencer that computes an 8x8 2D DCT by time-sharing one external dct_1d_8x1 row unit.
- Sequence: accept 8 input rows, issue 8 row passes, transpose, issue 8 column passes, then stream 8 output rows.
- Sits between the block fetcher and the quantiser, driving the 1D unit's data_in and sampling its dct_out.

Parameters:
- DATA_WIDTH, 32, width of one sample/coefficient word.
- DCT_LATENCY, 4, cycles from a value on dct_data_in to its result on dct_data_out (>=0).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  input row valid.
- in_ready  out  1  input row accepted when in_valid&&in_ready.
- in_data  in  DATA_WIDTH*8  one row; word j at [j*DATA_WIDTH +: DATA_WIDTH].
- dct_data_in  out  DATA_WIDTH*8  vector to the 1D unit.
- dct_data_out  in  DATA_WIDTH*8  result from the 1D unit.
- out_valid  out  1  output row valid.
- out_ready  in  1  output row consumed on handshake.
- out_data  out  DATA_WIDTH*8  output row.
- out_last  out  1  high with output row 7.
- busy  out  1  state != LOAD.

Behaviour:
- Clocking: single clock. Reset is asynchronous and active-high.
- States: LOAD -> ROW -> COL -> OUT -> LOAD. Reset enters LOAD with all counters 0.
- Reset values: out_valid=0, out_last=0, busy=0, in_ready=0 while reset is high, dct_data_in=0. Buffer contents are don't-care.
- LOAD:
  - in_ready=1.
  - Each handshake writes in_data into ibuf[rcnt] and increments rcnt.
  - The edge accepting row 7 (E0) moves to ROW. Gaps in in_valid are allowed.
- ROW (N = 8+DCT_LATENCY cycles, local cycle k=0..N-1):
  - For k<8, dct_data_in = ibuf[k]. Otherwise dct_data_in = 0.
  - At the end of cycle k>=DCT_LATENCY, dct_data_out is written to tbuf[k-DCT_LATENCY].
  - Latency is tracked with an 8+DCT_LATENCY issue shift register; the 1D unit has no valid.
  - After cycle N-1, go to COL.
- COL (N cycles):
  - For k<8, dct_data_in word r = tbuf[r] word k (column gather). Otherwise 0.
  - Result for column c is captured into obuf[c] at the end of cycle c+DCT_LATENCY.
  - After cycle N-1, go to OUT.
- OUT:
  - out_valid=1. out_data word j = obuf[j] word ocnt (transpose back).
  - out_last = (ocnt==7).
  - While out_ready=0, out_data and out_last are held stable.
  - On the handshake of row 7, go to LOAD and deassert out_valid on the next cycle.
- Timing: out_valid first rises 2N cycles after E0 (24 for DCT_LATENCY=4). No overlap between blocks.
- in_ready=0 in ROW/COL/OUT. Input is ignored there.
- Reset mid-operation aborts immediately. The next block starts cleanly from LOAD.
- No arithmetic is done in this block. Widths pass through unchanged.

Optional Feature:
- Macro DCT_SEQ_PERF_EN.
- Defined:
  - Adds outputs blk_cycles[31:0] and blk_count[15:0], both reset to 0.
  - blk_cycles: cycles from the first input handshake of a block to the last output handshake, updated at block end.
  - blk_count: increments per completed block and wraps at 65535->0.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package dct_pkg:
  - DCT_N=8.
  - State enum (LOAD=0, ROW=1, COL=2, OUT=3).
  - Row/column index typedef (3 bits).
- Sub-module dct_transpose_buf: 8x8 word register array with row write, row read and column read. Instantiated for ibuf/tbuf/obuf or shared where legal.

Test Plan:
- Identity: bench model of the 1D unit as identity with 4-cycle delay; X[r][c]=8r+c, back-to-back input -> output row k word j = 8k+j; first out_valid exactly 24 cycles after the 8th accept; out_last only on row 7.
- Reversal model (word j <- word 7-j), same X -> out[k][j] = 63-(8k+j).
- Backpressure: out_ready low 5 cycles at row 3 -> out_data stable, no row skipped/duplicated, in_ready=0 throughout.
- Input gaps: in_valid toggling 1/0 -> only handshaked rows stored; result identical to the identity case.
- Reset asserted in COL cycle 6 -> outputs at reset values immediately; after release in_ready=1; next block correct.
- DCT_SEQ_PERF_EN, DCT_LATENCY=4, no stalls -> blk_cycles=39, blk_count increments 0->1->2 over two blocks.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and types for the 8x8 2D DCT sequencer.
// Contents: block dimension, sequencer state encoding, row/column index type.
// Imported by dct_transpose_buf and dct_2d_seq.
package dct_pkg;

  localparam int DCT_N = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic [2:0] idx_t;

endpackage

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: 8x8 array of DATA_WIDTH words with one row write port
// and one combinational read port that returns either a row or a column.
// Ports: clk; we/waddr/wdata row write; addr/col_sel/rdata read
//   (col_sel=0: rdata = row addr; col_sel=1: rdata word r = row r word addr).
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [2:0]                    waddr,
  input  logic [DATA_WIDTH*DCT_N-1:0]   wdata,
  input  logic [2:0]                    addr,
  input  logic                          col_sel,
  output logic [DATA_WIDTH*DCT_N-1:0]   rdata
);

  logic [DATA_WIDTH*DCT_N-1:0] mem [DCT_N];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem[addr];
    if (col_sel) begin
      for (int r = 0; r < DCT_N; r++) begin
        rdata[r*DATA_WIDTH +: DATA_WIDTH] = mem[r][int'(addr)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/dct_2d_seq.sv
// dct_2d_seq: sequences an 8x8 2D DCT over one external 1D unit
// (load 8 rows, 8 row passes, 8 column passes, stream 8 output rows).
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data input rows;
//   dct_data_in/dct_data_out to/from the 1D unit; out_valid/out_ready/
//   out_data/out_last output rows; busy = not in LOAD.
// Optional macro DCT_SEQ_PERF_EN adds blk_cycles[31:0] and blk_count[15:0].
module dct_2d_seq
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DCT_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH*8-1:0] in_data,
  output logic [DATA_WIDTH*8-1:0] dct_data_in,
  input  logic [DATA_WIDTH*8-1:0] dct_data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH*8-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
`ifdef DCT_SEQ_PERF_EN
  ,
  output logic [31:0]             blk_cycles,
  output logic [15:0]             blk_count
`endif
);

  // One pass issues 8 vectors and waits DCT_LATENCY more cycles for results.
  localparam int N  = DCT_N + DCT_LATENCY;
  localparam int KW = $clog2(N) + 1;

  state_t          state, state_nxt;
  idx_t            rcnt, ocnt;
  logic [KW-1:0]   kcnt;
  logic            in_hs, out_hs;
  logic            issue, cap, kend;
  idx_t            cap_idx;
  logic [N-2:0]    iss_sr;
  logic [N-1:0]    iss_hist;

  logic                    a_we, b_we;
  idx_t                    a_waddr;
  logic [DATA_WIDTH*8-1:0] a_wdata, a_rdata;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // A vector goes to the 1D unit in the first 8 cycles of a pass.
  assign issue = ((state == ROW) || (state == COL)) && (kcnt < KW'(DCT_N));

  // iss_hist[i] = "a vector was issued i cycles ago". Its result is on
  // dct_data_out when i == DCT_LATENCY. The history is cleared at each pass
  // end, so the oldest tap fires only on the last cycle of a pass.
  assign iss_hist = {iss_sr, issue};
  assign cap      = iss_hist[DCT_LATENCY];
  assign kend     = iss_hist[N-1];
  assign cap_idx  = idx_t'(kcnt - KW'(DCT_LATENCY));

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_hs && (rcnt == idx_t'(DCT_N - 1))) state_nxt = ROW;
      ROW:     if (kend) state_nxt = COL;
      COL:     if (kend) state_nxt = OUT;
      OUT:     if (out_hs && (ocnt == idx_t'(DCT_N - 1))) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    in_ready    = (state == LOAD) && !reset;
    out_valid   = (state == OUT);
    out_last    = (state == OUT) && (ocnt == idx_t'(DCT_N - 1));
    busy        = (state != LOAD);
    dct_data_in = '0;
    if (issue) begin
      dct_data_in = a_rdata;
    end
  end

  // ---------------- counters and issue history ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt   <= '0;
      ocnt   <= '0;
      kcnt   <= '0;
      iss_sr <= '0;
    end else begin
      if ((state == LOAD) && in_hs) begin
        rcnt <= rcnt + 1'b1;
      end
      if (out_hs) begin
        ocnt <= ocnt + 1'b1;
      end
      if (((state == ROW) || (state == COL)) && !kend) begin
        kcnt <= kcnt + 1'b1;
      end else begin
        kcnt <= '0;
      end
      if (kend) begin
        iss_sr <= '0;
      end else begin
        iss_sr <= iss_hist[N-2:0];
      end
    end
  end

  // ---------------- buffers ----------------
  // Buffer A holds the input block and is then overwritten by row-pass
  // results: row r is read at cycle r and rewritten at cycle r+DCT_LATENCY,
  // so it is never clobbered before it is issued. The column pass needs a
  // separate buffer because it reads every row while writing result rows.
  assign a_we    = ((state == LOAD) && in_hs) || ((state == ROW) && cap);
  assign a_waddr = (state == LOAD) ? rcnt : cap_idx;
  assign a_wdata = (state == LOAD) ? in_data : dct_data_out;
  assign b_we    = (state == COL) && cap;

  dct_transpose_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf_a (
    .clk     (clk),
    .we      (a_we),
    .waddr   (a_waddr),
    .wdata   (a_wdata),
    .addr    (kcnt[2:0]),
    .col_sel (state == COL),
    .rdata   (a_rdata)
  );

  // Row c of buffer B holds column c's result; reading column ocnt undoes
  // that transpose, and holding ocnt keeps out_data stable under stall.
  dct_transpose_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf_b (
    .clk     (clk),
    .we      (b_we),
    .waddr   (cap_idx),
    .wdata   (dct_data_out),
    .addr    (ocnt),
    .col_sel (1'b1),
    .rdata   (out_data)
  );

`ifdef DCT_SEQ_PERF_EN
  // run_cnt equals the number of edges since the block's first input
  // handshake; it is latched on the final output handshake.
  logic [31:0] run_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt    <= '0;
      blk_cycles <= '0;
      blk_count  <= '0;
    end else begin
      if ((state == LOAD) && in_hs && (rcnt == '0)) begin
        run_cnt <= 32'd1;
      end else if ((state != LOAD) || (rcnt != '0)) begin
        run_cnt <= run_cnt + 32'd1;
      end
      if (out_hs && (ocnt == idx_t'(DCT_N - 1))) begin
        blk_cycles <= run_cnt;
        blk_count  <= blk_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dct_2d_seq.sv
// tb_dct_2d_seq: self-checking bench for dct_2d_seq with a behavioural
// 1D unit (identity or word reversal, DCT_LATENCY-cycle delay).
// Expected rows are queued when a block is driven and popped on output.
module tb_dct_2d_seq;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int N  = 8 + L;
  localparam int VW = W * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [VW-1:0] dct_data_in;
  logic [VW-1:0] dct_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef DCT_SEQ_PERF_EN
  logic [31:0]   blk_cycles;
  logic [15:0]   blk_count;
`endif

  always #5 clk = ~clk;

  dct_2d_seq #(.DATA_WIDTH(W), .DCT_LATENCY(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .dct_data_in  (dct_data_in),
    .dct_data_out (dct_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
`ifdef DCT_SEQ_PERF_EN
    ,
    .blk_cycles   (blk_cycles),
    .blk_count    (blk_count)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int mode     = 0;

  logic [VW-1:0] xrow [8];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] pipe [L];
  logic [VW-1:0] garb;

  function automatic logic [VW-1:0] f1d(input int m, input logic [VW-1:0] v);
    logic [VW-1:0] r;
    for (int j = 0; j < 8; j++) begin
      r[j*W +: W] = (m != 0) ? v[(7-j)*W +: W] : v[j*W +: W];
    end
    return r;
  endfunction

  // Behavioural 1D unit: transform applied on entry, then L register stages.
  always @(posedge clk) begin
    pipe[0] <= f1d(mode, dct_data_in);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign dct_data_out = pipe[L-1];

  task automatic chk_i(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_v(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Builds X[r][c] = base+8r+c into xrow and queues the expected output
  // rows: row pass, column pass, result read back row-major.
  task automatic build_expect(input int m, input int base);
    logic [VW-1:0] arow [8];
    logic [VW-1:0] bcol [8];
    logic [VW-1:0] v;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) xrow[r][c*W +: W] = W'(base + 8*r + c);
      arow[r] = f1d(m, xrow[r]);
    end
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) v[r*W +: W] = arow[r][c*W +: W];
      bcol[c] = f1d(m, v);
    end
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) v[j*W +: W] = bcol[j][k*W +: W];
      exp_q.push_back(v);
    end
  endtask

  // Drives one block and checks its output. Called just after a posedge.
  task automatic run_block(input int m, input int base, input bit gaps,
                           input int stall_row, input int stall_len,
                           input int exp_lat, input int exp_cycles, input int exp_count);
    int sent = 0, got = 0, cyc = 0, t = -1, lat = -1, ir_bad = 0, stall_left;
    bit prev_stall = 0;
    logic [VW-1:0] prev_data, e;
    logic prev_last;
    stall_left = stall_len;
    mode = m;
    build_expect(m, base);
    while (got < 8 && cyc < 400) begin
      if (sent < 8) begin
        in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
        in_data  = in_valid ? xrow[sent] : garb;
      end else begin
        in_valid = 1'b1;   // must be ignored while busy
        in_data  = garb;
      end
      if (out_valid && got == stall_row && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (t >= 0) t++;
      if (busy && in_ready) ir_bad++;
      if (prev_stall) begin
        chk_v("stall_hold_data", out_data, prev_data);
        chk_i("stall_hold_last", int'(out_last), int'(prev_last));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && lat < 0) lat = t - 1;
      if (in_valid && in_ready) begin
        sent++;
        if (sent == 8) t = 0;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk_v("row_data", out_data, e);
        chk_i("row_last", int'(out_last), int'(got == 7));
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (got < 8) begin
      checks++;
      failures++;
      $display("FAIL block_timeout rows_seen=%0d required=8", got);
      exp_q.delete();
    end
    chk_i("first_valid_latency", lat, exp_lat);
    chk_i("in_ready_while_busy", ir_bad, 0);
    chk_i("post_out_valid", int'(out_valid), 0);
    chk_i("post_busy", int'(busy), 0);
    chk_i("post_in_ready", int'(in_ready), 1);
`ifdef DCT_SEQ_PERF_EN
    chk_i("perf_blk_cycles", int'(blk_cycles), exp_cycles);
    chk_i("perf_blk_count", int'(blk_count), exp_count);
`else
    if (exp_cycles < 0 || exp_count < 0) $display("note: negative perf expectation");
`endif
  endtask

  typedef struct {
    int mode;
    int base;
    bit gaps;
    int stall_row;
    int stall_len;
    int exp_lat;
    int exp_cycles;
  } vec_t;

  vec_t tv [4];

  initial begin
    logic [VW-1:0] colv;
    garb = {8{32'hDEAD_BEEF}};

    tv[0] = '{mode: 0, base: 0,   gaps: 1'b0, stall_row: -1, stall_len: 0, exp_lat: 2*N, exp_cycles: 39};
    tv[1] = '{mode: 1, base: 0,   gaps: 1'b0, stall_row: -1, stall_len: 0, exp_lat: 2*N, exp_cycles: 39};
    tv[2] = '{mode: 0, base: 100, gaps: 1'b0, stall_row: 3,  stall_len: 5, exp_lat: 2*N, exp_cycles: 44};
    tv[3] = '{mode: 0, base: 0,   gaps: 1'b1, stall_row: -1, stall_len: 0, exp_lat: 2*N, exp_cycles: 46};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk_i("rst_in_ready", int'(in_ready), 0);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_i("rst_out_last", int'(out_last), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_v("rst_dct_data_in", dct_data_in, '0);
`ifdef DCT_SEQ_PERF_EN
    chk_i("rst_blk_cycles", int'(blk_cycles), 0);
    chk_i("rst_blk_count", int'(blk_count), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_i("rel_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 4; i++) begin
      run_block(tv[i].mode, tv[i].base, tv[i].gaps, tv[i].stall_row,
                tv[i].stall_len, tv[i].exp_lat, tv[i].exp_cycles, i + 1);
    end

    // Abort in COL cycle 6, then a clean block.
    mode = 0;
    build_expect(0, 0);
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      in_data  = xrow[r];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (N + 6) @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) colv[r*W +: W] = xrow[r][6*W +: W];
    chk_i("col6_busy", int'(busy), 1);
    chk_v("col6_gather", dct_data_in, colv);
    reset = 1'b1;
    #1;
    chk_i("abort_out_valid", int'(out_valid), 0);
    chk_i("abort_out_last", int'(out_last), 0);
    chk_i("abort_busy", int'(busy), 0);
    chk_i("abort_in_ready", int'(in_ready), 0);
    chk_v("abort_dct_data_in", dct_data_in, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_i("abort_rel_in_ready", int'(in_ready), 1);
    chk_i("abort_rel_busy", int'(busy), 0);
    run_block(1, 7, 1'b0, -1, 0, 2*N, 39, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
